// File: rtl/uart_rx_frontend_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_frontend_if
// Description : Signal bundle between a UART receiver front end and its
//               surroundings.
//                 srx_pad_i - raw serial line (idle 1), asynchronous to clk
//                 dl        - 16x-tick divisor in clk cycles (0 = disabled)
//                 dl_load   - one-cycle pulse: dl has just been rewritten
//                 srx_o     - synchronised / filtered serial line
//                 enable_o  - one-clk-wide 16x oversampling tick
//                 break_o   - line-break indication
//               master : drives the line and divisor, observes the outputs
//               slave  : the front end itself
// Revision    : 1.0 - initial release
// ============================================================================
interface uart_rx_frontend_if;
  logic        srx_pad_i;
  logic [15:0] dl;
  logic        dl_load;
  logic        srx_o;
  logic        enable_o;
  logic        break_o;

  modport master (
    output srx_pad_i, dl, dl_load,
    input  srx_o, enable_o, break_o
  );

  modport slave (
    input  srx_pad_i, dl, dl_load,
    output srx_o, enable_o, break_o
  );
endinterface
`default_nettype wire

// File: rtl/uart_rx_frontend.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_frontend
// Description : Receive-side front end of a UART. Resynchronises the serial
//               line, optionally removes single-clock glitches, generates
//               the 16x oversampling tick from the divisor and flags a line
//               break after 192 consecutive low ticks (12 bit-times).
// Ports       : clk       - system clock, rising edge
//               wb_rst_i  - asynchronous active-high reset
//               bus       - uart_rx_frontend_if.slave (line, divisor,
//                           srx_o / enable_o / break_o)
// Config      : define UART_RX_GLITCH_FILTER_EN to compile in the 3-sample
//               majority glitch filter (stable-change latency 4 clk instead
//               of 3).
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_frontend (
  input  wire                  clk,
  input  wire                  wb_rst_i,
  uart_rx_frontend_if.slave    bus
);

  // Last count value before break is declared: 192 ticks = counts 0..191.
  localparam logic [7:0] c_BRK_LAST = 8'd191;

  logic        r_sync1;
  logic        r_sync2;
  logic        r_srx;
  logic [15:0] r_dlc;
  logic        r_enable;
  logic [7:0]  r_brk_cnt;
  logic        r_break;

  logic        w_dl_zero;
  logic [15:0] w_dl_m1;

  assign w_dl_zero = (bus.dl == 16'd0);
  assign w_dl_m1   = bus.dl - 16'd1;

  // --------------------------------------------------------------------------
  // Line resynchroniser and optional majority filter
  // --------------------------------------------------------------------------
`ifdef UART_RX_GLITCH_FILTER_EN
  logic r_s0;
  logic r_s1;

  always_ff @(posedge clk or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_s0    <= 1'b1;
      r_s1    <= 1'b1;
      r_srx   <= 1'b1;
    end else begin
      r_sync1 <= bus.srx_pad_i;
      r_sync2 <= r_sync1;
      r_s0    <= r_sync2;
      r_s1    <= r_s0;
      // A one-clk pulse occupies only one of the three taps at any time,
      // so the 2-of-3 vote never passes it.
      r_srx   <= (r_sync2 & r_s0) | (r_sync2 & r_s1) | (r_s0 & r_s1);
    end
  end
`else
  always_ff @(posedge clk or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_srx   <= 1'b1;
    end else begin
      r_sync1 <= bus.srx_pad_i;
      r_sync2 <= r_sync1;
      r_srx   <= r_sync2;
    end
  end
`endif

  // --------------------------------------------------------------------------
  // Baud tick generator
  // --------------------------------------------------------------------------
  // dlc == 0 after reset, so the first tick appears on the first edge after
  // release. A dl_load suppresses the tick in its own cycle and reloads
  // dl-1, which puts the next tick exactly dl cycles after the load edge.
  always_ff @(posedge clk or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_dlc    <= 16'd0;
      r_enable <= 1'b0;
    end else begin
      r_enable <= !w_dl_zero && (r_dlc == 16'd0) && !bus.dl_load;
      if (w_dl_zero) begin
        r_dlc <= 16'd0;
      end else if (bus.dl_load) begin
        r_dlc <= w_dl_m1;
      end else if (r_dlc == 16'd0) begin
        r_dlc <= w_dl_m1;
      end else begin
        r_dlc <= r_dlc - 16'd1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Break detector
  // --------------------------------------------------------------------------
  // Frozen while the divisor is disabled. A high line always wins over a
  // coincident tick. The counter saturates at its last value; break stays
  // set until the line returns high.
  always_ff @(posedge clk or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_brk_cnt <= 8'd0;
      r_break   <= 1'b0;
    end else if (!w_dl_zero) begin
      if (r_srx) begin
        r_brk_cnt <= 8'd0;
        r_break   <= 1'b0;
      end else if (r_enable) begin
        if (r_brk_cnt == c_BRK_LAST) begin
          r_break <= 1'b1;
        end else begin
          r_brk_cnt <= r_brk_cnt + 8'd1;
        end
      end
    end
  end

  assign bus.srx_o    = r_srx;
  assign bus.enable_o = r_enable;
  assign bus.break_o  = r_break;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_frontend.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx_frontend
// Description : Self-checking bench for uart_rx_frontend. Expected tick
//               cycles and line latencies are queued when stimulus is driven
//               and compared when the DUT responds.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_frontend;

  logic clk = 1'b0;
  logic wb_rst_i;

  uart_rx_frontend_if u_if ();

  uart_rx_frontend dut (
    .clk      (clk),
    .wb_rst_i (wb_rst_i),
    .bus      (u_if.slave)
  );

  always #5 clk = ~clk;

`ifdef UART_RX_GLITCH_FILTER_EN
  localparam int c_LAT        = 4;
  localparam int c_GLITCH_LOW = 0;
  localparam int c_HIGH_PULSE = 2;
`else
  localparam int c_LAT        = 3;
  localparam int c_GLITCH_LOW = 1;
  localparam int c_HIGH_PULSE = 1;
`endif

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit sb_on = 1'b0;
  int q_tick[$];
  int q_lat[$];

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d (cyc=%0d)", tag, got, exp, cyc);
    end
  endtask

  // One clock: sample 1 ns after the edge and score any tick seen.
  task automatic step();
    int exp_c;
    @(posedge clk);
    #1;
    cyc++;
    if (sb_on && u_if.enable_o) begin
      if (q_tick.size() == 0) begin
        chk("stray_tick", cyc, -1);
      end else begin
        exp_c = q_tick.pop_front();
        chk("tick_cyc", cyc, exp_c);
      end
    end
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic push_ticks(input int first, input int period, input int count);
    for (int i = 0; i < count; i++) q_tick.push_back(first + i * period);
  endtask

  // Drive the pad and queue the expected edge count until srx_o follows.
  task automatic drive_pad(input logic lvl);
    u_if.srx_pad_i = lvl;
    q_lat.push_back(c_LAT);
  endtask

  task automatic wait_srx(input logic lvl, input string tag);
    int k;
    int e;
    k = 0;
    while (k < 12 && u_if.srx_o !== lvl) begin
      step();
      k++;
    end
    e = (q_lat.size() != 0) ? q_lat.pop_front() : -1;
    chk(tag, k, e);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, total=%0d", total);
    $fatal(1);
  end

  initial begin
    int n;
    int brk_seen;
    int low_cnt;
    bit pend;

    // ---------------- reset state ----------------
    wb_rst_i       = 1'b1;
    u_if.srx_pad_i = 1'b1;
    u_if.dl        = 16'd4;
    u_if.dl_load   = 1'b0;
    #12;
    chk("rst_enable", u_if.enable_o, 0);
    chk("rst_break",  u_if.break_o,  0);
    chk("rst_srx",    u_if.srx_o,    1);

    // ---------------- dl=4 after release: ticks 1,5,9,13,17 ----------------
    @(posedge clk);
    #1;
    wb_rst_i = 1'b0;
    cyc      = 0;
    sb_on    = 1'b1;
    push_ticks(1, 4, 5);
    steps(17);
    chk("dl4_q_empty", q_tick.size(), 0);

    // ---------------- dl=1: tick every cycle ----------------
    u_if.dl      = 16'd1;
    u_if.dl_load = 1'b1;
    step();
    u_if.dl_load = 1'b0;
    push_ticks(cyc + 1, 1, 8);
    steps(8);
    chk("dl1_q_empty", q_tick.size(), 0);

    // ---------------- dl=10, then dl=3 loaded mid-count, then dl=0 ---------
    u_if.dl      = 16'd10;
    u_if.dl_load = 1'b1;
    step();
    u_if.dl_load = 1'b0;
    push_ticks(cyc + 10, 10, 1);
    steps(15);
    u_if.dl      = 16'd3;
    u_if.dl_load = 1'b1;
    step();
    u_if.dl_load = 1'b0;
    push_ticks(cyc + 3, 3, 3);
    steps(9);
    u_if.dl = 16'd0;
    steps(10);
    chk("reload_q_empty", q_tick.size(), 0);
    sb_on = 1'b0;

    // ---------------- line latency and glitch ----------------
    drive_pad(1'b0);
    wait_srx(1'b0, "fall_latency");
    steps(3);
    drive_pad(1'b1);
    wait_srx(1'b1, "rise_latency");
    steps(3);
    u_if.srx_pad_i = 1'b0;
    step();
    u_if.srx_pad_i = 1'b1;
    low_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (u_if.srx_o == 1'b0) low_cnt++;
    end
    chk("glitch_low_cycles", low_cnt, c_GLITCH_LOW);

    // ---------------- break after 192 ticks at dl=2 ----------------
    u_if.dl      = 16'd2;
    u_if.dl_load = 1'b1;
    step();
    u_if.dl_load = 1'b0;
    drive_pad(1'b0);
    wait_srx(1'b0, "brk_fall_latency");
    n    = 0;
    pend = 1'b0;
    for (int i = 0; i < 600 && n < 195; i++) begin
      step();
      if (pend) begin
        n++;
        if (n == 191) begin
          chk("brk_at_191", u_if.break_o, 0);
          chk("brkcnt_at_191", int'(dut.r_brk_cnt), 191);
        end
        if (n == 192) chk("brk_at_192", u_if.break_o, 1);
        if (n == 195) begin
          chk("brk_sat", u_if.break_o, 1);
          chk("brkcnt_sat", int'(dut.r_brk_cnt), 191);
        end
      end
      pend = u_if.enable_o && !u_if.srx_o;
    end
    chk("brk_ticks_seen", n, 195);
    drive_pad(1'b1);
    wait_srx(1'b1, "brk_rise_latency");
    chk("brk_hold_at_rise", u_if.break_o, 1);
    step();
    chk("brk_clear", u_if.break_o, 0);
    chk("brkcnt_clear", int'(dut.r_brk_cnt), 0);

    // ---------------- 100 low ticks, short high, 100 low ticks ----------
    brk_seen = 0;
    drive_pad(1'b0);
    wait_srx(1'b0, "split_fall_latency");
    for (int i = 0; i < 200; i++) begin
      step();
      if (u_if.break_o) brk_seen++;
    end
    u_if.srx_pad_i = 1'b1;
    for (int i = 0; i < c_HIGH_PULSE; i++) begin
      step();
      if (u_if.break_o) brk_seen++;
    end
    u_if.srx_pad_i = 1'b0;
    for (int i = 0; i < 210; i++) begin
      step();
      if (u_if.break_o) brk_seen++;
    end
    chk("split_no_break", brk_seen, 0);

    // ---------------- async reset while break set and mid-count ----------
    u_if.dl      = 16'd4;
    u_if.dl_load = 1'b1;
    step();
    u_if.dl_load = 1'b0;
    n = 0;
    while (n < 1000 && !u_if.break_o) begin
      step();
      n++;
    end
    chk("pre_rst_break", u_if.break_o, 1);
    steps(2);
    #2;
    wb_rst_i = 1'b1;
    #1;
    chk("arst_enable", u_if.enable_o, 0);
    chk("arst_break",  u_if.break_o,  0);
    chk("arst_srx",    u_if.srx_o,    1);
    chk("arst_dlc",    int'(dut.r_dlc), 0);
    steps(3);
    chk("in_rst_srx",    u_if.srx_o,    1);
    chk("in_rst_enable", u_if.enable_o, 0);
    u_if.srx_pad_i = 1'b1;
    step();
    wb_rst_i = 1'b0;
    sb_on    = 1'b1;
    push_ticks(cyc + 1, 4, 2);
    steps(6);
    chk("post_rst_q_empty", q_tick.size(), 0);
    chk("post_rst_break", u_if.break_o, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_rx_frontend.md
UART_RX_FRONTEND -- requirements
Module: uart_rx_frontend

Interface
REQ-001 The block SHALL have the port clk, input, 1 bit: system clock; all state updates on its rising edge.
REQ-002 The block SHALL have the port wb_rst_i, input, 1 bit: reset, asynchronous, active-high.
REQ-003 The block SHALL have the port srx_pad_i, input, 1 bit: raw serial line, asynchronous to clk; idle level 1.
REQ-004 The block SHALL have the port dl, input, 16 bits: baud divisor in clk cycles per 16x tick; value 0 means disabled.
REQ-005 The block SHALL have the port dl_load, input, 1 bit: one-cycle pulse marking that dl has been rewritten.
REQ-006 The block SHALL have the port srx_o, output, 1 bit: synchronised (and optionally filtered) line that feeds the receiver's serial input.
REQ-007 The block SHALL have the port enable_o, output, 1 bit: 16x oversampling tick that feeds the receiver's enable; one clk wide.
REQ-008 The block SHALL have the port break_o, output, 1 bit: line-break indication.

Function
REQ-009 The block SHALL resynchronise srx_pad_i through two flops, sync1 then sync2, both reset to 1.
REQ-010 The block SHALL register srx_o, with reset value 1.
REQ-011 The baud counter dlc SHALL be 16 bits wide, with reset value 0.
REQ-012 On every clk edge, enable_o SHALL be loaded with (dl != 0) && (dlc == 0) && !dl_load; its reset value is 0.
REQ-013 On each clk edge, dlc SHALL update by the first matching rule below (priority order, exactly one rule applies):
REQ-014 Rule 1 (highest priority): when dl == 0, dlc SHALL be set to 0 and no ticks SHALL be generated.
REQ-015 Rule 2: when dl_load == 1, dlc SHALL be set to dl-1.
REQ-016 Rule 3: when dlc == 0, dlc SHALL be set to dl-1.
REQ-017 Rule 4 (otherwise): dlc SHALL decrement by 1.
REQ-018 In steady state the enable_o period SHALL be exactly dl clk cycles; dl = 1 SHALL give enable_o high on every cycle.
REQ-019 The first enable_o SHALL appear one clk after reset release when dl != 0.
REQ-020 After a dl_load pulse, the next enable_o SHALL occur exactly dl cycles after the pulse edge; the new rate SHALL take effect with no stray short tick.
REQ-021 The break counter brk_cnt SHALL be 8 bits, with reset value 0.
REQ-022 While srx_o == 1, brk_cnt SHALL be cleared to 0 and break_o SHALL be cleared to 0 on the next edge.
REQ-023 While srx_o == 0, brk_cnt SHALL increment on each enable_o, saturating at 191.
REQ-024 break_o SHALL be set on an enable_o with srx_o == 0 and brk_cnt == 191, i.e. the line has been low for 192 ticks (12 bit-times), and SHALL stay set until srx_o returns to 1.
REQ-025 When an enable_o and srx_o == 1 occur in the same cycle, the clear SHALL win.
REQ-026 When dl == 0, brk_cnt and break_o SHALL hold their values; srx_o SHALL continue to track the line.

Reset
REQ-027 Asserting wb_rst_i at any time, including mid-frame or mid-count, SHALL immediately force: sync1, sync2, filter samples and srx_o to 1; dlc and brk_cnt to 0; enable_o and break_o to 0.
REQ-028 No tick, break or line transition SHALL be produced while wb_rst_i is high.
REQ-029 Operation SHALL resume on the first edge after deassertion, per REQ-019.

Configuration
REQ-030 The macro UART_RX_GLITCH_FILTER_EN SHALL select whether the glitch filter is compiled in.
REQ-031 When UART_RX_GLITCH_FILTER_EN is defined, two delay flops s0 and s1 (reset 1) SHALL follow sync2, and srx_o SHALL be loaded with the majority of (sync2, s0, s1) on every clk.
REQ-032 With UART_RX_GLITCH_FILTER_EN defined, a stable level change on srx_pad_i SHALL reach srx_o after 4 clk edges.
REQ-033 With UART_RX_GLITCH_FILTER_EN defined, a pulse on sync2 that is one clk wide SHALL never reach srx_o.
REQ-034 When UART_RX_GLITCH_FILTER_EN is undefined, srx_o SHALL be loaded from sync2 on every clk, giving a stable-change latency of 3 clk edges, with no filtering; s0 and s1 SHALL be absent.

Verification
REQ-035 Scenario: dl=4, reset released -> enable_o high at edge 1, then every 4 clks (edges 5, 9, 13, ...); dl=1 -> enable_o continuously high.
REQ-036 Scenario: dl=10 running, then dl=3 with a dl_load pulse mid-count -> enable_o low in the load cycle, next tick exactly 3 clks later, then period 3; dl=0 -> enable_o stays 0.
REQ-037 Scenario: filter compiled in, srx_pad_i 1->0 held -> srx_o falls after edge 4; a 1-clk low glitch -> srx_o stays 1. Filter compiled out, same step -> srx_o falls after edge 3 and the glitch passes through.
REQ-038 Scenario: dl=2, line held low 191 ticks -> break_o=0; at the 192nd tick -> break_o=1; line returns to 1 -> break_o=0 and brk_cnt=0 one clk after srx_o rises.
REQ-039 Scenario: line low for 100 ticks, high for 1 clk, then low for 100 ticks -> break_o never asserts.
REQ-040 Scenario: wb_rst_i pulsed while break_o=1 and dlc mid-count -> all outputs at reset values asynchronously; with dl=4 the first tick occurs 1 clk after release.
